// File: rtl/pmc_hw_accelerator_ctrl.sv
// Load/compute/unload sequencer for the PMC accelerator shift path.
// Optional RUN watchdog is enabled by defining PMC_HW_ACC_CTRL_TIMEOUT_EN.
module pmc_hw_accelerator_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pm_addr,
    output logic              pm_rd,
    output logic              pm_wr,
    output logic              sh_a,
    output logic              core_start,
    input  logic              core_done
);
    localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_RD, S_LD_SH, S_RUN_GO, S_RUN_WAIT, S_UL, S_FIN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [KW-1:0]     r_k, w_k_nxt;
    logic [ADDR_W-1:0] r_src, r_dst, w_src_base;
    logic [ADDR_W-1:0] r_pm_addr, w_pm_addr;
    logic              r_busy, r_done, r_pm_rd, r_pm_wr, r_sh_a, r_core_start;
    logic              w_busy, w_done, w_pm_rd, w_pm_wr, w_sh_a, w_core_start;
    logic              w_err;
    logic              w_wd_exp;

`ifdef PMC_HW_ACC_CTRL_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd;
    logic           r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd  <= (r_state == S_RUN_WAIT) ? r_wd + 1'b1 : '0;
            r_err <= w_err;
        end
    end

    // Expiry flags the TIMEOUT-th consecutive RUN_WAIT cycle
    assign w_wd_exp = (r_wd == WDW'(TIMEOUT - 1));
    assign err      = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_wd_exp         = 1'b0;
    assign err              = 1'b0;
`endif

    // The address must be usable in the accept cycle, before it is latched
    assign w_src_base = (r_state == S_IDLE) ? src_addr : r_src;

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_err        = 1'b0;
        w_pm_addr    = '0;
        w_pm_rd      = 1'b0;
        w_pm_wr      = 1'b0;
        w_sh_a       = 1'b0;
        w_core_start = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LD_RD;
                    w_k_nxt     = '0;
                end
            end
            S_LD_RD:  w_state_nxt = S_LD_SH;
            S_LD_SH: begin
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_RUN_GO;
                end else begin
                    w_k_nxt     = r_k + 1'b1;
                    w_state_nxt = S_LD_RD;
                end
            end
            S_RUN_GO: w_state_nxt = S_RUN_WAIT;
            S_RUN_WAIT: begin
                if (core_done) begin
                    w_state_nxt = S_UL;
                end else if (w_wd_exp) begin
                    w_state_nxt = S_FIN;
                    w_err       = 1'b1;
                end
            end
            S_UL: begin
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_FIN;
                end else begin
                    w_k_nxt     = r_k + 1'b1;
                end
            end
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered
        case (w_state_nxt)
            S_LD_RD: begin
                w_pm_addr = w_src_base + ADDR_W'(w_k_nxt);
                w_pm_rd   = 1'b1;
            end
            S_LD_SH:  w_sh_a       = 1'b1;
            S_RUN_GO: w_core_start = 1'b1;
            S_UL: begin
                w_pm_addr = r_dst + ADDR_W'(w_k_nxt);
                w_pm_wr   = 1'b1;
                w_sh_a    = 1'b1;
            end
            S_FIN:    w_done = 1'b1;
            default:  ;
        endcase
        w_busy = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_pm_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pm_rd      <= 1'b0;
            r_pm_wr      <= 1'b0;
            r_sh_a       <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            if (r_state == S_IDLE && start) begin
                r_src <= src_addr;
                r_dst <= dst_addr;
            end
            r_pm_addr    <= w_pm_addr;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_pm_rd      <= w_pm_rd;
            r_pm_wr      <= w_pm_wr;
            r_sh_a       <= w_sh_a;
            r_core_start <= w_core_start;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pm_addr    = r_pm_addr;
    assign pm_rd      = r_pm_rd;
    assign pm_wr      = r_pm_wr;
    assign sh_a       = r_sh_a;
    assign core_start = r_core_start;

endmodule
